// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and the
// MEM-stage load/store port; MEM has fixed priority, and every access ends with a one-cycle DONE.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              bus_err,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q;
    owner_t              owner_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic                cancel_q;
    logic                bus_err_q;
    logic                bus_stb_q;
    logic                bus_we_q;
    logic [3:0]          bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    assign cnt_d = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            cancel_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_stb_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cancel_q <= 1'b0;
                    cnt_q    <= '0;
                    if (mem_req) begin
                        bus_we_q    <= mem_we;
                        bus_sel_q   <= mem_sel;
                        bus_addr_q  <= mem_addr;
                        bus_wdata_q <= mem_wdata;
                        bus_stb_q   <= 1'b1;
                        owner_q     <= OWN_MEM;
                        state_q     <= BUSY;
                    end else if (if_req && !flush) begin
                        bus_we_q   <= 1'b0;
                        bus_sel_q  <= 4'b1111;
                        bus_addr_q <= if_addr;
                        bus_stb_q  <= 1'b1;
                        owner_q    <= OWN_IF;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    // A flush landing on the ack cycle itself must also suppress the fetch result.
                    if (flush && owner_q == OWN_IF)
                        cancel_q <= 1'b1;
                    if (bus_ack) begin
                        bus_stb_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        state_q   <= DONE;
                        if (owner_q == OWN_MEM && !bus_we_q)
                            mem_rdata_q <= bus_rdata;
                        else if (owner_q == OWN_IF && !cancel_q && !flush)
                            if_rdata_q <= bus_rdata;
                    end else if (cnt_q == TO_LAST) begin
                        bus_stb_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                        if (owner_q == OWN_MEM)
                            mem_rdata_q <= '0;
                        else if (owner_q == OWN_IF && !cancel_q && !flush)
                            if_rdata_q <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                end
                default: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign mem_stall = mem_req & ~(state_q == DONE && owner_q == OWN_MEM);
    assign if_stall  = if_req & ~(state_q == DONE && owner_q == OWN_IF && !cancel_q);

    assign bus_err   = bus_err_q;
    assign bus_stb   = bus_stb_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store, contention, flush, timeout and reset scenarios.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        bus_err;
    logic        bus_stb;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .bus_err   (bus_err),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        flush = 0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_sel = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus_stb, bus_we, bus_err, bus_sel} !== 7'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000000", {bus_stb, bus_we, bus_err, bus_sel});
        end
        total++;
        if ({bus_addr, bus_wdata, if_rdata, mem_rdata} !== 128'd0) begin
            bad++; $display("FAIL reset_data got addr=%h wdata=%h ird=%h mrd=%h want all 0",
                            bus_addr, bus_wdata, if_rdata, mem_rdata);
        end
        @(negedge clk);
        rst = 0;
        $display("reset: outputs checked");
    endtask

    task automatic test_fetch;
        logic [4:0] stall_exp;
        logic [4:0] stb_exp;
        stall_exp = 5'b01111;
        stb_exp   = 5'b01110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if_req = 1; if_addr = 32'h0000_0100;
            bus_ack = (c == 3); bus_rdata = (c == 3) ? 32'h2401_0005 : 32'h0;
            #1;
            total++;
            if (if_stall !== stall_exp[c]) begin
                bad++; $display("FAIL fetch_stall c%0d got=%b want=%b", c, if_stall, stall_exp[c]);
            end
            total++;
            if (bus_stb !== stb_exp[c]) begin
                bad++; $display("FAIL fetch_stb c%0d got=%b want=%b", c, bus_stb, stb_exp[c]);
            end
            if (c == 1) begin
                total++;
                if (bus_addr !== 32'h100 || bus_sel !== 4'hF || bus_we !== 1'b0) begin
                    bad++; $display("FAIL fetch_bus got addr=%h sel=%h we=%b want 00000100 f 0",
                                    bus_addr, bus_sel, bus_we);
                end
            end
        end
        total++;
        if (if_rdata !== 32'h2401_0005) begin
            bad++; $display("FAIL fetch_rdata got=%h want=24010005", if_rdata);
        end
        @(negedge clk);
        idle_inputs();
        $display("fetch: addr=00000100 if_rdata=%h", if_rdata);
    endtask

    task automatic test_store;
        logic [3:0] stall_exp;
        stall_exp = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_req = 1; mem_we = 1; mem_sel = 4'b0011;
            mem_addr = 32'h8000_0004; mem_wdata = 32'hDEAD_BEEF;
            bus_ack = (c == 2); bus_rdata = 32'hFFFF_FFFF;
            #1;
            total++;
            if (mem_stall !== stall_exp[c]) begin
                bad++; $display("FAIL store_stall c%0d got=%b want=%b", c, mem_stall, stall_exp[c]);
            end
            if (c == 1) begin
                total++;
                if (bus_stb !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b0011 ||
                    bus_addr !== 32'h8000_0004 || bus_wdata !== 32'hDEAD_BEEF) begin
                    bad++; $display("FAIL store_bus got stb=%b we=%b sel=%h addr=%h wdata=%h want 1 1 3 80000004 deadbeef",
                                    bus_stb, bus_we, bus_sel, bus_addr, bus_wdata);
                end
            end
        end
        total++;
        if (mem_rdata !== 32'h0 || bus_stb !== 1'b0) begin
            bad++; $display("FAIL store_done got mrd=%h stb=%b want 00000000 0", mem_rdata, bus_stb);
        end
        @(negedge clk);
        idle_inputs();
        $display("store: addr=80000004 wdata=deadbeef sel=3");
    endtask

    task automatic test_contention;
        logic [5:0] stb_exp;
        logic [5:0] if_stall_exp;
        logic [5:0] mem_stall_exp;
        stb_exp       = 6'b010010;
        if_stall_exp  = 6'b011111;
        mem_stall_exp = 6'b000011;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_req = (c <= 2); mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h40;
            if_req = 1; if_addr = 32'h200;
            bus_ack = (c == 1 || c == 4);
            bus_rdata = (c == 1) ? 32'hAAAA_5555 : 32'h5555_AAAA;
            #1;
            total++;
            if (bus_stb !== stb_exp[c] || if_stall !== if_stall_exp[c] || mem_stall !== mem_stall_exp[c]) begin
                bad++; $display("FAIL contend_ctl c%0d got stb=%b ist=%b mst=%b want %b %b %b", c,
                                bus_stb, if_stall, mem_stall, stb_exp[c], if_stall_exp[c], mem_stall_exp[c]);
            end
            if (c == 1 || c == 4) begin
                total++;
                if (bus_addr !== ((c == 1) ? 32'h40 : 32'h200)) begin
                    bad++; $display("FAIL contend_addr c%0d got=%h want=%h", c, bus_addr,
                                    (c == 1) ? 32'h40 : 32'h200);
                end
            end
            if (c == 2) begin
                total++;
                if (mem_rdata !== 32'hAAAA_5555) begin
                    bad++; $display("FAIL contend_mrd got=%h want=aaaa5555", mem_rdata);
                end
            end
        end
        total++;
        if (if_rdata !== 32'h5555_AAAA) begin
            bad++; $display("FAIL contend_ird got=%h want=5555aaaa", if_rdata);
        end
        @(negedge clk);
        idle_inputs();
        $display("contention: mem_rdata=%h if_rdata=%h", mem_rdata, if_rdata);
    endtask

    task automatic test_flush;
        logic [7:0] stall_exp;
        logic [7:0] stb_exp;
        stall_exp = 8'b0111_1111;
        stb_exp   = 8'b0100_1110;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if_req = 1; if_addr = (c <= 4) ? 32'h300 : 32'h400;
            flush = (c == 1);
            bus_ack = (c == 3 || c == 6);
            bus_rdata = (c == 3) ? 32'h1234_5678 : 32'h0BAD_C0DE;
            #1;
            total++;
            if (if_stall !== stall_exp[c] || bus_stb !== stb_exp[c]) begin
                bad++; $display("FAIL flush_ctl c%0d got ist=%b stb=%b want %b %b", c,
                                if_stall, bus_stb, stall_exp[c], stb_exp[c]);
            end
            if (c == 4) begin
                total++;
                if (if_rdata !== 32'h5555_AAAA) begin
                    bad++; $display("FAIL flush_keep got=%h want=5555aaaa", if_rdata);
                end
            end
            if (c == 6) begin
                total++;
                if (bus_addr !== 32'h400) begin
                    bad++; $display("FAIL flush_next_addr got=%h want=00000400", bus_addr);
                end
            end
        end
        total++;
        if (if_rdata !== 32'h0BAD_C0DE) begin
            bad++; $display("FAIL flush_next_rd got=%h want=0badc0de", if_rdata);
        end
        @(negedge clk);
        idle_inputs();
        $display("flush: cancelled fetch dropped, next if_rdata=%h", if_rdata);
    endtask

    task automatic test_timeout;
        logic [5:0] stb_exp;
        logic [5:0] err_exp;
        logic [5:0] stall_exp;
        stb_exp   = 6'b011110;
        err_exp   = 6'b100000;
        stall_exp = 6'b011111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h50;
            #1;
            total++;
            if (bus_stb !== stb_exp[c] || bus_err !== err_exp[c] || mem_stall !== stall_exp[c]) begin
                bad++; $display("FAIL timeout_ctl c%0d got stb=%b err=%b mst=%b want %b %b %b", c,
                                bus_stb, bus_err, mem_stall, stb_exp[c], err_exp[c], stall_exp[c]);
            end
        end
        total++;
        if (mem_rdata !== 32'h0) begin
            bad++; $display("FAIL timeout_rd got=%h want=00000000", mem_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (bus_err !== 1'b0 || bus_stb !== 1'b0) begin
            bad++; $display("FAIL timeout_after got err=%b stb=%b want 0 0", bus_err, bus_stb);
        end
        $display("timeout: load at 00000050 aborted, mem_rdata=%h", mem_rdata);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h60;
        @(negedge clk);
        #1;
        total++;
        if (bus_stb !== 1'b1) begin
            bad++; $display("FAIL rstmid_busy got stb=%b want 1", bus_stb);
        end
        rst = 1;
        @(negedge clk);
        rst = 0; mem_req = 0; bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        #1;
        total++;
        if ({bus_stb, bus_we, bus_err, bus_sel} !== 7'd0 ||
            {bus_addr, bus_wdata, if_rdata, mem_rdata} !== 128'd0) begin
            bad++; $display("FAIL rstmid_state got stb=%b addr=%h ird=%h mrd=%h want all 0",
                            bus_stb, bus_addr, if_rdata, mem_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (mem_rdata !== 32'h0 || if_rdata !== 32'h0 || bus_stb !== 1'b0 || bus_err !== 1'b0) begin
            bad++; $display("FAIL rstmid_stray got mrd=%h ird=%h stb=%b err=%b want 0 0 0 0",
                            mem_rdata, if_rdata, bus_stb, bus_err);
        end
        $display("reset_mid: access dropped, stray ack ignored");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
